// File: rtl/pipe_pkg.sv
// Shared constants for the MEM->WB pipeline buffer: stall/reset levels, payload field layout
// and the write-enable gating helper used when a bubble is presented downstream.
package pipe_pkg;

   localparam logic STOP          = 1'b1;
   localparam logic NOT_STOP      = 1'b0;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic RST_ENABLE    = 1'b1;

   // Enable bits occupy the payload LSBs so bubble masking is a fixed low-order slice.
   localparam int REG_WE_BIT    = 0;
   localparam int HILO_WE_BIT   = 1;
   localparam int CP0_WE_BIT    = 2;
   localparam int LLBIT_WE_BIT  = 3;
   localparam int EN_DEF_W      = LLBIT_WE_BIT + 1;

   localparam int REG_ADDR_W    = 5;
   localparam int REG_ADDR_LSB  = EN_DEF_W;
   localparam int REG_DATA_W    = 32;
   localparam int REG_DATA_LSB  = REG_ADDR_LSB + REG_ADDR_W;
   localparam int HI_W          = 32;
   localparam int HI_LSB        = REG_DATA_LSB + REG_DATA_W;
   localparam int LO_W          = 32;
   localparam int LO_LSB        = HI_LSB + HI_W;
   // CP0 write data travels in the reg data field; only its address needs its own slot.
   localparam int CP0_ADDR_W    = 5;
   localparam int CP0_ADDR_LSB  = LO_LSB + LO_W;
   localparam int LLBIT_W       = 1;
   localparam int LLBIT_LSB     = CP0_ADDR_LSB + CP0_ADDR_W;
   localparam int SPARE_W       = 2;
   localparam int SPARE_LSB     = LLBIT_LSB + LLBIT_W;
   localparam int PAYLOAD_DEF_W = SPARE_LSB + SPARE_W;

   function automatic logic gate_enable(input logic enBit, input logic keep);
      return keep ? enBit : WRITE_DISABLE;
   endfunction

endpackage

// File: rtl/pipe_buf_core.sv
// Circular storage for the MEM->WB buffer: wrapping pointers, entry count and a registered
// in_ready derived from the next-state count.
module pipe_buf_core
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_DEF_W,
   parameter int DEPTH     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   input  logic [PAYLOAD_W-1:0]       wr_data_i,
   output logic [PAYLOAD_W-1:0]       rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       in_ready_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 in_ready_q, in_ready_d;

   // Explicit wrap keeps non-power-of-two depths legal.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = ptr_next(wr_ptr_q);
         if (pop_i)  rd_ptr_d = ptr_next(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      in_ready_d = (count_d < CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Storage needs no reset: an entry is only observable while count covers it.
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o  = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign in_ready_o = in_ready_q;

endmodule

// File: rtl/mem_wb_pipe_buf.sv
// MEM->WB elastic pipeline buffer with stall gating, flush priority and bubble masking.
// Optional saturating stall/bubble counters are enabled with `define PIPE_BUF_STATS_EN.
module mem_wb_pipe_buf
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_DEF_W,
   parameter int EN_W      = EN_DEF_W,
   parameter int DEPTH     = 2,
   parameter int STALL_W   = 6,
   parameter int STAGE_IDX = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PAYLOAD_W-1:0]       in_payload,
   input  logic [STALL_W-1:0]         stall,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PAYLOAD_W-1:0]       out_payload,
`ifdef PIPE_BUF_STATS_EN
   output logic [31:0]                stall_cycles,
   output logic [31:0]                bubble_cycles,
`endif
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   logic                       accept;
   logic                       drain;
   logic [PAYLOAD_W-1:0]       headData;
   logic [PAYLOAD_W-1:0]       headPayload;
   logic [$clog2(DEPTH+1)-1:0] count;

   assign accept = in_valid && in_ready && (stall[STAGE_IDX] == NOT_STOP);
   assign drain  = out_valid && out_ready && (stall[STAGE_IDX+1] == NOT_STOP);

   pipe_buf_core #(
      .PAYLOAD_W (PAYLOAD_W),
      .DEPTH     (DEPTH)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .push_i     (accept),
      .pop_i      (drain),
      .clear_i    (flush),
      .wr_data_i  (in_payload),
      .rd_data_o  (headData),
      .count_o    (count),
      .in_ready_o (in_ready)
   );

   assign out_valid = (count != '0);
   assign occupancy = count;

   // Enables are gated on out_valid so an emptied buffer never repeats a stale write.
   always_comb begin
      headPayload = out_valid ? headData : '0;
      out_payload = headPayload;
      for (int i = 0; i < EN_W; i++) begin
         out_payload[i] = gate_enable(headPayload[i], out_valid);
      end
   end

`ifdef PIPE_BUF_STATS_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] bubble_cycles_q;

   // Counters saturate and survive flush; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         stall_cycles_q  <= '0;
         bubble_cycles_q <= '0;
      end else begin
         if (out_valid && (stall[STAGE_IDX+1] == STOP) && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_q <= stall_cycles_q + 32'd1;
         if (!out_valid && (bubble_cycles_q != 32'hFFFF_FFFF))
            bubble_cycles_q <= bubble_cycles_q + 32'd1;
      end
   end

   assign stall_cycles  = stall_cycles_q;
   assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_buf.sv
// Directed, table-driven bench for mem_wb_pipe_buf (DEPTH=2) plus hand-written throughput
// and asynchronous-reset sequences.
module tb_mem_wb_pipe_buf;

   localparam int PW = 113;

   typedef struct {
      logic          inValid;
      logic [PW-1:0] inPayload;
      logic [5:0]    stall;
      logic          flush;
      logic          outReady;
      logic          expValid;
      logic          expReady;
      logic [1:0]    expOcc;
      logic [PW-1:0] expPayload;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          inValid;
   logic          inReady;
   logic [PW-1:0] inPayload;
   logic [5:0]    stall;
   logic          flush;
   logic          outValid;
   logic          outReady;
   logic [PW-1:0] outPayload;
   logic [1:0]    occupancy;
`ifdef PIPE_BUF_STATS_EN
   logic [31:0]   stallCycles;
   logic [31:0]   bubbleCycles;
`endif

   int checks = 0;
   int errors = 0;
   vec_t vecs [17];

   mem_wb_pipe_buf dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (inValid),
      .in_ready      (inReady),
      .in_payload    (inPayload),
      .stall         (stall),
      .flush         (flush),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .out_payload   (outPayload),
`ifdef PIPE_BUF_STATS_EN
      .stall_cycles  (stallCycles),
      .bubble_cycles (bubbleCycles),
`endif
      .occupancy     (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PW-1:0] mk(input logic [PW-5:0] data, input logic [3:0] en);
      return {data, en};
   endfunction

   task automatic checkOutput(input string name, input logic [PW-1:0] actual,
                              input logic [PW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic eValid, input logic eReady,
                           input logic [1:0] eOcc, input logic [PW-1:0] ePayload);
      checkOutput({tag, ".out_valid"}, PW'(outValid), PW'(eValid));
      checkOutput({tag, ".in_ready"}, PW'(inReady), PW'(eReady));
      checkOutput({tag, ".occupancy"}, PW'(occupancy), PW'(eOcc));
      checkOutput({tag, ".out_payload"}, outPayload, ePayload);
   endtask

   // Drive inputs, then sample one time unit after the edge that consumes them.
   task automatic applyStimulus(input logic iv, input logic [PW-1:0] pl, input logic [5:0] st,
                                input logic fl, input logic ordy);
      inValid   = iv;
      inPayload = pl;
      stall     = st;
      flush     = fl;
      outReady  = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single write / drain
      vecs[0]  = '{1'b1, mk(109'hA5, 4'b0001), 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, mk(109'hA5, 4'b0001)};
      vecs[1]  = '{1'b0, '0,                  6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0};
      // Backpressure: fill, hold third, release in order
      vecs[2]  = '{1'b1, mk(109'd1, 4'hF),    6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(109'd1, 4'hF)};
      vecs[3]  = '{1'b1, mk(109'd2, 4'hF),    6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(109'd1, 4'hF)};
      vecs[4]  = '{1'b1, mk(109'd3, 4'hF),    6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(109'd1, 4'hF)};
      vecs[5]  = '{1'b1, mk(109'd3, 4'hF),    6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, mk(109'd2, 4'hF)};
      vecs[6]  = '{1'b1, mk(109'd3, 4'hF),    6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, mk(109'd3, 4'hF)};
      vecs[7]  = '{1'b0, '0,                  6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0};
      // Stall bubble: capture blocked, held entry drains, then masked bubble
      vecs[8]  = '{1'b1, mk(109'd4, 4'h3),    6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(109'd4, 4'h3)};
      vecs[9]  = '{1'b1, mk(109'd5, 4'h3),    6'b010000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0};
      vecs[10] = '{1'b1, mk(109'd5, 4'h3),    6'b010000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0};
      vecs[11] = '{1'b1, mk(109'd5, 4'h3),    6'b010000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0};
      // Frozen with both stall bits, then drain-only stall
      vecs[12] = '{1'b1, mk(109'd6, 4'h2),    6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(109'd6, 4'h2)};
      vecs[13] = '{1'b1, mk(109'd7, 4'h4),    6'b110000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, mk(109'd6, 4'h2)};
      vecs[14] = '{1'b1, mk(109'd7, 4'h4),    6'b100000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, mk(109'd6, 4'h2)};
      // Flush beats simultaneous accept and drain
      vecs[15] = '{1'b1, mk(109'd8, 4'h1),    6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, '0};
      vecs[16] = '{1'b0, '0,                  6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0};

      rst = 1'b1;
      inValid = 1'b0; inPayload = '0; stall = '0; flush = 1'b0; outReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset", 1'b0, 1'b1, 2'd0, '0);
`ifdef PIPE_BUF_STATS_EN
      checkOutput("reset.stall_cycles", PW'(stallCycles), '0);
      checkOutput("reset.bubble_cycles", PW'(bubbleCycles), '0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].inValid, vecs[i].inPayload, vecs[i].stall, vecs[i].flush,
                       vecs[i].outReady);
         checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expReady, vecs[i].expOcc,
                  vecs[i].expPayload);
      end

      // Full throughput: each payload appears the cycle after it is accepted.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, mk(109'(k+1), 4'h1), 6'b000000, 1'b0, 1'b1);
         checkAll($sformatf("thru%0d", k), 1'b1, 1'b1, 2'd1, mk(109'(k+1), 4'h1));
      end
      applyStimulus(1'b0, '0, 6'b000000, 1'b0, 1'b1);
      checkAll("thru_end", 1'b0, 1'b1, 2'd0, '0);

      // Asynchronous reset between edges with two entries held.
      applyStimulus(1'b1, mk(109'h11, 4'hF), 6'b000000, 1'b0, 1'b0);
      applyStimulus(1'b1, mk(109'h22, 4'hF), 6'b000000, 1'b0, 1'b0);
      checkAll("pre_rst", 1'b1, 1'b0, 2'd2, mk(109'h11, 4'hF));
      inValid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkAll("async_rst", 1'b0, 1'b1, 2'd0, '0);
`ifdef PIPE_BUF_STATS_EN
      checkOutput("async_rst.stall_cycles", PW'(stallCycles), '0);
      checkOutput("async_rst.bubble_cycles", PW'(bubbleCycles), '0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, '0, 6'b000000, 1'b0, 1'b1);
      checkAll("post_rst", 1'b0, 1'b1, 2'd0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe_buf.md
Name: mem_wb_pipe_buf

Overview:
- Parametrised MEM→WB pipeline stage. Replaces the single-register stage with a DEPTH-entry elastic buffer.
- Carries one packed payload: reg, hi/lo, cp0 and LLbit write data plus their enables.
- Supports a valid/ready handshake, the global stall vector, synchronous flush, and bubble masking of write-enable bits.
- Sits between the memory-access stage and the regfile/hilo/cp0/LLbit write ports.

Parameters:
- PAYLOAD_W, 113, total packed payload width (enables in LSBs, data above).
- EN_W, 4, number of payload LSBs that are write enables, forced to 0 on any bubble.
- DEPTH, 2, buffer entries (≥1); 2 gives full throughput.
- STALL_W, 6, stall vector width.
- STAGE_IDX, 4, stall bit governing capture; bit STAGE_IDX+1 governs drain (STAGE_IDX+1 < STALL_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  MEM stage presents a payload.
- in_ready  out  1  buffer can accept; registered, no combinational path from out_ready.
- in_payload  in  PAYLOAD_W  packed MEM results.
- stall  in  STALL_W  global stall vector (1 = stop).
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  WB consumer accepts head.
- out_payload  out  PAYLOAD_W  head payload; enable bits masked to 0 when out_valid=0.
- occupancy  out  $clog2(DEPTH+1)  entries held.

Behaviour:
- Reset (async, immediate): count=0, rd_ptr=wr_ptr=0, out_valid=0, out_payload=0, in_ready=1, occupancy=0. Storage contents don't-care but never visible.
- accept = in_valid & in_ready & ~stall[STAGE_IDX].
- drain = out_valid & out_ready & ~stall[STAGE_IDX+1].
- Storage is a circular buffer. Pointers increment with explicit wrap at DEPTH-1 → 0, so non-power-of-2 DEPTH is legal.
- Latency: an entry accepted into an empty buffer appears on out_payload/out_valid the next cycle. There is no same-cycle pass-through.
- Output: out_valid = (count≠0). out_payload = entry[rd_ptr] when valid; otherwise data bits are 0 and the enable bits are 0.
- Count update:
  - accept only: +1.
  - drain only: −1.
  - both: unchanged; pointers both advance.
- in_ready is registered from the next-state count: next in_ready = (next count < DEPTH).
  - At count=DEPTH, in_ready=0 and no accept occurs even if drain occurs that cycle.
  - DEPTH=1 therefore sustains at most one transfer per two cycles. This is documented, not a bug.
- Bubble rule: stall[STAGE_IDX]=1 with stall[STAGE_IDX+1]=0 inserts no entry. Downstream sees out_valid=0 with masked enables once the buffer empties, so no stale write is repeated.
- Both stall bits=1: buffer frozen; count, pointers and outputs hold.
- Flush has priority over accept and drain in the same cycle. Next cycle: count=0, pointers=0, out_valid=0, in_ready=1. The flushed head must not be consumed as a write.
- Reset mid-operation: all in-flight entries are lost immediately; no write enable may be asserted after rst rises.
- occupancy = count, registered.

Optional Feature:
- Macro PIPE_BUF_STATS_EN.
- Defined: adds two outputs, each saturating at 32'hFFFF_FFFF and cleared by rst only (flush does not clear them):
  - stall_cycles [31:0]: increments each cycle stall[STAGE_IDX+1]=1 while out_valid=1.
  - bubble_cycles [31:0]: increments each cycle out_valid=0.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package pipe_pkg:
  - stall constants STOP/NOT_STOP.
  - WRITE_DISABLE.
  - RST_ENABLE (1'b1).
  - Payload field offsets/widths for reg/hi/lo/cp0/LLbit packing.
  - Function for enable-bit masking.
- Sub-module pipe_buf_core: circular storage, pointers, count and in_ready generation. The top level adds stall gating, flush priority, output masking and the optional counters.

Test Plan:
- Reset then single write: rst pulse; in_valid=1 with payload 0x...A5|en=4'b0001 for one cycle, out_ready=1 → out_valid=1 exactly one cycle later with that payload; occupancy returns 0 the following cycle.
- Full throughput: DEPTH=2, 8 back-to-back payloads 1..8, out_ready=1, no stall → 8 consecutive out_valid cycles in order 1..8; in_ready never drops.
- Backpressure/full: out_ready=0, push 3 payloads → in_ready=0 after 2 accepted, occupancy=2; third held by source; release out_ready → 1,2,3 delivered in order.
- Stall bubble: stall[4]=1, stall[5]=0 for 3 cycles with buffer initially holding one entry → that entry drains, then out_valid=0 and out_payload[EN_W-1:0]=0 for remaining cycles.
- Flush priority: buffer holding 2 entries, assert flush with in_valid=1 and out_ready=1 same cycle → next cycle occupancy=0, out_valid=0, new payload not captured.
- Async reset mid-stream: raise rst between clock edges with occupancy=2 → out_valid, out_payload and enables go to 0 before the next clk edge; with PIPE_BUF_STATS_EN, both counters read 0.
